// File: rtl/cnn_window_gen_if.sv
// Stream-in / window-out handshake bundle for cnn_window_gen.
// slave is the generator side; master is the pixel source plus downstream FIFO.
interface cnn_window_gen_if #(
    parameter int WIDTH = 8
);
    logic                 i_valid;
    logic [WIDTH-1:0]     i_data;
    logic                 o_ready;
    logic [9*WIDTH-1:0]   o_window;
    logic                 o_enq;
    logic                 i_full;
    logic                 o_frame_done;

    modport master (
        output i_valid, i_data, i_full,
        input  o_ready, o_window, o_enq, o_frame_done
    );

    modport slave (
        input  i_valid, i_data, i_full,
        output o_ready, o_window, o_enq, o_frame_done
    );
endinterface

// File: rtl/cnn_window_gen.sv
// Raster pixel stream to 3x3 sliding window generator feeding a 9-entry parallel-write FIFO.
// Define CNN_WIN_STRIDE2_EN to emit only every second window in both directions (stride 2).
module cnn_window_gen #(
    parameter int WIDTH = 8,
    parameter int IMG_W = 28,
    parameter int IMG_H = 28
) (
    input logic              i_clk,
    input logic              i_rstn,
    cnn_window_gen_if.slave  bus
);

    localparam int MAXD = (IMG_W > IMG_H) ? IMG_W : IMG_H;
    localparam int CW   = $clog2(MAXD);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0] ROW_LAST = CW'(IMG_H - 1);
    localparam logic [CW-1:0] TWO      = CW'(2);

`ifdef CNN_WIN_STRIDE2_EN
    localparam logic [CW-1:0] LAST_EM_ROW = CW'(2 + 2 * ((IMG_H - 3) / 2));
    localparam logic [CW-1:0] LAST_EM_COL = CW'(2 + 2 * ((IMG_W - 3) / 2));
`else
    localparam logic [CW-1:0] LAST_EM_ROW = ROW_LAST;
    localparam logic [CW-1:0] LAST_EM_COL = COL_LAST;
`endif

    typedef enum logic [1:0] {IDLE, STREAM, PEND, DONE} state_t;

    state_t              state;
    logic [CW-1:0]       row;
    logic [CW-1:0]       col;
    logic                ready_q;
    logic                pend_last;
    logic                pend_end;
    logic [9*WIDTH-1:0]  window_q;

    logic [WIDTH-1:0]    lb0 [IMG_W];
    logic [WIDTH-1:0]    lb1 [IMG_W];
    logic [WIDTH-1:0]    hist [3][2];

    logic                accept;
    logic                win_valid;
    logic                is_last;
    logic                at_end;
    logic [WIDTH-1:0]    col_new [3];
    logic [9*WIDTH-1:0]  win_next;

    // col_new is the freshly completed column: two buffered rows above plus the incoming pixel
    always_comb begin
        accept     = bus.i_valid & ready_q;
        col_new[0] = lb1[col];
        col_new[1] = lb0[col];
        col_new[2] = bus.i_data;
`ifdef CNN_WIN_STRIDE2_EN
        win_valid  = (row >= TWO) && (col >= TWO) && !row[0] && !col[0];
`else
        win_valid  = (row >= TWO) && (col >= TWO);
`endif
        at_end     = (row == ROW_LAST) && (col == COL_LAST);
        is_last    = (row == LAST_EM_ROW) && (col == LAST_EM_COL);
    end

    always_comb begin
        win_next = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 2; j++) begin
                win_next[(i*3+j)*WIDTH +: WIDTH] = hist[i][j];
            end
            win_next[(i*3+2)*WIDTH +: WIDTH] = col_new[i];
        end
    end

    // Storage is deliberately not reset; stale contents are never emitted before being refilled
    always_ff @(posedge i_clk) begin
        if (accept) begin
            lb1[col] <= lb0[col];
            lb0[col] <= bus.i_data;
            for (int i = 0; i < 3; i++) begin
                hist[i][0] <= hist[i][1];
                hist[i][1] <= col_new[i];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state     <= IDLE;
            row       <= '0;
            col       <= '0;
            ready_q   <= 1'b1;
            pend_last <= 1'b0;
            pend_end  <= 1'b0;
            window_q  <= '0;
        end else begin
            case (state)
                IDLE, STREAM: begin
                    if (accept) begin
                        if (col == COL_LAST) begin
                            col <= '0;
                            row <= (row == ROW_LAST) ? '0 : row + CW'(1);
                        end else begin
                            col <= col + CW'(1);
                        end
                        if (win_valid) begin
                            window_q  <= win_next;
                            pend_last <= is_last;
                            pend_end  <= at_end;
                            ready_q   <= 1'b0;
                            state     <= PEND;
                        end else begin
                            state     <= STREAM;
                        end
                    end
                end
                // Last window that is also the frame's final pixel closes the frame via DONE
                PEND: begin
                    if (!bus.i_full) begin
                        if (pend_last && pend_end) begin
                            state <= DONE;
                        end else begin
                            ready_q <= 1'b1;
                            state   <= STREAM;
                        end
                    end
                end
                DONE: begin
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_ready      = ready_q;
    assign bus.o_window     = window_q;
    assign bus.o_enq        = (state == PEND) && !bus.i_full;
    assign bus.o_frame_done = bus.o_enq && pend_last;

endmodule

// File: tb/tb_cnn_window_gen.sv
// Self-checking bench for cnn_window_gen: 4x4, 5x5 and 6x6 instances driven through one muxed stimulus port.
// Expected windows come from a frame-array reference model plus a table of hand-written windows.
module tb_cnn_window_gen;

`ifdef CNN_WIN_STRIDE2_EN
    localparam int STRIDE = 2;
    localparam int NTBL   = 1;
`else
    localparam int STRIDE = 1;
    localparam int NTBL   = 4;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic        valid;
    logic [7:0]  data;
    logic        full;
    int          sel;

    logic        ready;
    logic        enq;
    logic        done;
    logic [71:0] window;

    always #5 clk = ~clk;

    cnn_window_gen_if #(.WIDTH(8)) if_a ();
    cnn_window_gen_if #(.WIDTH(8)) if_b ();
    cnn_window_gen_if #(.WIDTH(8)) if_c ();

    cnn_window_gen #(.WIDTH(8), .IMG_W(4), .IMG_H(4)) dut_a (.i_clk(clk), .i_rstn(rstn), .bus(if_a));
    cnn_window_gen #(.WIDTH(8), .IMG_W(5), .IMG_H(5)) dut_b (.i_clk(clk), .i_rstn(rstn), .bus(if_b));
    cnn_window_gen #(.WIDTH(8), .IMG_W(6), .IMG_H(6)) dut_c (.i_clk(clk), .i_rstn(rstn), .bus(if_c));

    assign if_a.i_valid = valid && (sel == 0);
    assign if_b.i_valid = valid && (sel == 1);
    assign if_c.i_valid = valid && (sel == 2);
    assign if_a.i_data  = data;
    assign if_b.i_data  = data;
    assign if_c.i_data  = data;
    assign if_a.i_full  = full;
    assign if_b.i_full  = full;
    assign if_c.i_full  = full;

    always_comb begin
        ready  = if_a.o_ready;
        enq    = if_a.o_enq;
        done   = if_a.o_frame_done;
        window = if_a.o_window;
        case (sel)
            1: begin
                ready  = if_b.o_ready;
                enq    = if_b.o_enq;
                done   = if_b.o_frame_done;
                window = if_b.o_window;
            end
            2: begin
                ready  = if_c.o_ready;
                enq    = if_c.o_enq;
                done   = if_c.o_frame_done;
                window = if_c.o_window;
            end
            default: ;
        endcase
    end

    typedef struct {
        logic [71:0] win;
        logic        done;
    } ev_t;

    typedef struct {
        int          cap_idx;
        logic [71:0] win;
        logic        done;
    } vec_t;

    int          n_checks = 0;
    int          n_fails  = 0;
    int          img_w    = 4;
    int          img_h    = 4;
    int          n_acc    = 0;
    int          win_in_frame = 0;
    logic [7:0]  mem [6][6];
    ev_t         exp_q [$];
    ev_t         cap_q [$];
    ev_t         ref_q [$];
    vec_t        tbl [4];

    task automatic checkOutput(input string name, input logic [71:0] act, input logic [71:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic int frameWindows(input int w, input int h);
        return ((h - 2 + STRIDE - 1) / STRIDE) * ((w - 2 + STRIDE - 1) / STRIDE);
    endfunction

    function automatic logic [71:0] mk9(input int e0, input int e1, input int e2,
                                        input int e3, input int e4, input int e5,
                                        input int e6, input int e7, input int e8);
        return {8'(e8), 8'(e7), 8'(e6), 8'(e5), 8'(e4), 8'(e3), 8'(e2), 8'(e1), 8'(e0)};
    endfunction

    function automatic logic [71:0] addOff(input logic [71:0] w, input int add);
        logic [71:0] r;
        r = w;
        for (int k = 0; k < 9; k++) r[k*8 +: 8] = 8'(int'(w[k*8 +: 8]) + add);
        return r;
    endfunction

    // Reference model: store the accepted pixel at its raster position and cut windows from the frame array
    task automatic modelAccept(input logic [7:0] p);
        int  r;
        int  c;
        ev_t e;
        r = (n_acc / img_w) % img_h;
        c = n_acc % img_w;
        mem[r][c] = p;
        if (r >= 2 && c >= 2 && ((r - 2) % STRIDE) == 0 && ((c - 2) % STRIDE) == 0) begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    e.win[(i*3+j)*8 +: 8] = mem[r-2+i][c-2+j];
            win_in_frame++;
            e.done = (win_in_frame == frameWindows(img_w, img_h));
            exp_q.push_back(e);
        end
        n_acc++;
        if (n_acc % (img_w * img_h) == 0) win_in_frame = 0;
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (!rstn) begin
            exp_q.delete();
            n_acc = 0;
            win_in_frame = 0;
        end else begin
            checkOutput("enq_while_full", {71'd0, enq & full}, 72'd0);
            if (enq) begin
                e.win  = window;
                e.done = done;
                cap_q.push_back(e);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fails++;
                    $display("[TB] FAIL unexpected_enq: got window %0h, expected no enqueue", window);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("sb_window", window, e.win);
                    checkOutput("sb_frame_done", {71'd0, done}, {71'd0, e.done});
                end
            end
            if (valid && ready) modelAccept(data);
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic selectDut(input int k);
        sel = k;
        img_w = 4 + k;
        img_h = 4 + k;
        n_acc = 0;
        win_in_frame = 0;
        cap_q.delete();
    endtask

    task automatic applyStimulus(input int base, input int count, input bit gaps);
        bit acc;
        int budget;
        for (int i = 0; i < count; i++) begin
            if (gaps) begin
                for (int g = 0; g < 3 && $urandom_range(1, 0) == 1; g++) begin
                    valid = 1'b0;
                    cycle();
                end
            end
            valid = 1'b1;
            data  = 8'(base + i);
            acc = 1'b0;
            budget = 0;
            while (!acc && budget < 64) begin
                @(negedge clk);
                acc = ready;
                cycle();
                budget++;
            end
            if (!acc) begin
                n_checks++;
                n_fails++;
                $display("[TB] FAIL stall_timeout: pixel %0d not accepted, expected acceptance within 64 cycles", base + i);
            end
        end
        valid = 1'b0;
    endtask

    task automatic waitDrain();
        bit idle;
        idle = 1'b0;
        for (int b = 0; b < 40 && !idle; b++) begin
            @(negedge clk);
            idle = (exp_q.size() == 0) && ready;
        end
        checkOutput("drain", {71'd0, idle}, 72'd1);
        cycle();
    endtask

    task automatic checkTable(input int start, input int add);
        for (int i = 0; i < NTBL; i++) begin
            if (cap_q.size() <= start + tbl[i].cap_idx) begin
                n_checks++;
                n_fails++;
                $display("[TB] FAIL tbl_missing: got %0d windows, expected window %0d", cap_q.size(), start + tbl[i].cap_idx);
            end else begin
                checkOutput("tbl_window", cap_q[start + tbl[i].cap_idx].win, addOff(tbl[i].win, add));
                checkOutput("tbl_done", {71'd0, cap_q[start + tbl[i].cap_idx].done}, {71'd0, tbl[i].done});
            end
        end
    endtask

    task automatic checkReset();
        checkOutput("rst_window", window, 72'd0);
        checkOutput("rst_enq", {71'd0, enq}, 72'd0);
        checkOutput("rst_done", {71'd0, done}, 72'd0);
        checkOutput("rst_ready", {71'd0, ready}, 72'd1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [71:0] w1;
        int          tl [4];
        tbl[0] = '{0, mk9(1, 2, 3, 5, 6, 7, 9, 10, 11), 1'b0};
        tbl[1] = '{1, mk9(2, 3, 4, 6, 7, 8, 10, 11, 12), 1'b0};
        tbl[2] = '{2, mk9(5, 6, 7, 9, 10, 11, 13, 14, 15), 1'b0};
        tbl[3] = '{3, mk9(6, 7, 8, 10, 11, 12, 14, 15, 16), 1'b1};
`ifdef CNN_WIN_STRIDE2_EN
        tbl[0].done = 1'b1;
`endif
        w1 = tbl[0].win;

        rstn = 1'b0;
        valid = 1'b0;
        data = 8'd0;
        full = 1'b0;
        selectDut(0);
        repeat (3) cycle();
        @(negedge clk);
        checkReset();
        cycle();
        rstn = 1'b1;
        cycle();

        $display("[TB] 4x4 frame, no back-pressure");
        selectDut(0);
        applyStimulus(1, 16, 1'b0);
        waitDrain();
        checkOutput("count_4x4", 72'(cap_q.size()), 72'(frameWindows(4, 4)));
        checkTable(0, 0);

        $display("[TB] 4x4 frame with full held on first window");
        selectDut(0);
        full = 1'b1;
        fork
            applyStimulus(1, 16, 1'b0);
            begin
                bit seen;
                seen = 1'b0;
                for (int b = 0; b < 40 && !seen; b++) begin
                    @(negedge clk);
                    seen = !ready;
                end
                checkOutput("pend_seen", {71'd0, seen}, 72'd1);
                for (int k = 0; k < 5; k++) begin
                    if (k > 0) @(negedge clk);
                    checkOutput("hold_ready", {71'd0, ready}, 72'd0);
                    checkOutput("hold_enq", {71'd0, enq}, 72'd0);
                    checkOutput("hold_window", window, w1);
                end
                cycle();
                full = 1'b0;
                @(negedge clk);
                checkOutput("release_enq", {71'd0, enq}, 72'd1);
                checkOutput("release_window", window, w1);
            end
        join
        waitDrain();
        checkOutput("count_full", 72'(cap_q.size()), 72'(frameWindows(4, 4)));
        checkTable(0, 0);

        $display("[TB] two back-to-back 4x4 frames");
        selectDut(0);
        applyStimulus(1, 16, 1'b0);
        applyStimulus(101, 16, 1'b0);
        waitDrain();
        checkOutput("count_b2b", 72'(cap_q.size()), 72'(2 * frameWindows(4, 4)));
        checkTable(0, 0);
        checkTable(NTBL, 100);

        $display("[TB] 5x5 frame, gap-free then random gaps");
        selectDut(1);
        applyStimulus(1, 25, 1'b0);
        waitDrain();
        ref_q = cap_q;
        checkOutput("count_5x5", 72'(ref_q.size()), 72'(frameWindows(5, 5)));
        selectDut(1);
        applyStimulus(1, 25, 1'b1);
        waitDrain();
        checkOutput("count_gaps", 72'(cap_q.size()), 72'(ref_q.size()));
        for (int i = 0; i < ref_q.size() && i < cap_q.size(); i++) begin
            checkOutput("gap_window", cap_q[i].win, ref_q[i].win);
            checkOutput("gap_done", {71'd0, cap_q[i].done}, {71'd0, ref_q[i].done});
        end

        $display("[TB] reset mid-frame, then a fresh 4x4 frame");
        selectDut(0);
        applyStimulus(1, 7, 1'b0);
        rstn = 1'b0;
        cycle();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checkReset();
            cycle();
        end
        rstn = 1'b1;
        cycle();
        selectDut(0);
        applyStimulus(1, 16, 1'b0);
        waitDrain();
        checkOutput("count_after_rst", 72'(cap_q.size()), 72'(frameWindows(4, 4)));
        checkTable(0, 0);

        $display("[TB] 6x6 frame");
        selectDut(2);
        applyStimulus(1, 36, 1'b0);
        waitDrain();
        checkOutput("count_6x6", 72'(cap_q.size()), 72'(frameWindows(6, 6)));
`ifdef CNN_WIN_STRIDE2_EN
        tl = '{1, 3, 13, 15};
`else
        tl = '{1, 2, 3, 4};
`endif
        for (int i = 0; i < 4 && i < cap_q.size(); i++) begin
            checkOutput("tl_6x6", {64'd0, cap_q[i].win[7:0]}, 72'(tl[i]));
        end
        if (cap_q.size() > 0)
            checkOutput("done_6x6", {71'd0, cap_q[cap_q.size()-1].done}, 72'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
